uart_tx_buffered: RTL and testbench

- Parametrised UART transmitter, next generation of the single-byte TX.
- Configurable data width, parity mode and stop bits.
- Small input FIFO behind a valid/ready handshake, so frames go out back-to-back.
- Bit timing comes from an internal clock-enable divider on the single system clock; no derived clocks.

---
 rtl/uart_tx_buffered.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: small input FIFO feeding a start/data/parity/stop framer.
// Define UART_TX_BREAK_EN to add the break_req port and a line-break state.
module uart_tx_buffered #(
    parameter int CLK_DIV     = 4,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                          break_req
`endif
);

    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = AW + 1;
    localparam int BW         = $clog2(CLK_DIV);
    localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
    localparam int NW         = $clog2(2 * FRAME_BITS + 1);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_buffered: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } state_t;

    state_t state, state_next;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop, fifo_empty;

    logic [BW-1:0]        baud_cnt;
    logic                 bit_end;
    logic [NW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_bit, parity_next;
    logic                 tx_next;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign data_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = data_valid && data_ready;
    assign bit_end    = (baud_cnt == BW'(CLK_DIV - 1));
    assign tx_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The line value for the next bit is decided here so tx is always a clean register output.
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        tx_next      = tx;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        parity_next  = parity_bit;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_next   = BREAK;
                    tx_next      = 1'b0;
                    bit_cnt_next = '0;
                end else
`endif
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    tx_next      = shift_reg[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == NW'(DATA_BITS - 1)) begin
                        if (PARITY_MODE != 0) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next   = STOP;
                            tx_next      = 1'b1;
                            bit_cnt_next = '0;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + NW'(1);
                        tx_next      = shift_reg[1];
                        shift_next   = shift_reg >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == NW'(STOP_BITS - 1)) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            tx_next    = 1'b0;
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + NW'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (bit_end) begin
                    if (bit_cnt == NW'(2 * FRAME_BITS - 1)) begin
                        state_next   = STOP;
                        tx_next      = 1'b1;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + NW'(1);
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
        if (pop) begin
            shift_next  = head;
            parity_next = (PARITY_MODE == 2) ? ~(^head) : (^head);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            state      <= state_next;
            tx         <= tx_next;
            bit_cnt    <= bit_cnt_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            if (state == IDLE || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: default instance plus odd-parity and 7N2 instances.
// Break test is compiled only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, tx, tx_busy;
    logic [2:0] fifo_count;
    logic       break_req;

    logic [7:0] odd_data_in;
    logic       odd_valid, odd_ready, odd_tx, odd_busy;
    logic [2:0] odd_count;

    logic [6:0] fmt_data_in;
    logic       fmt_valid, fmt_ready, fmt_tx, fmt_busy;
    logic [2:0] fmt_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_tx_buffered dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
`ifdef UART_TX_BREAK_EN
        , .break_req(break_req)
`endif
    );

    uart_tx_buffered #(.PARITY_MODE(2)) dut_odd (
        .clk(clk), .reset(reset), .data_in(odd_data_in), .data_valid(odd_valid),
        .data_ready(odd_ready), .tx(odd_tx), .tx_busy(odd_busy), .fifo_count(odd_count)
`ifdef UART_TX_BREAK_EN
        , .break_req(1'b0)
`endif
    );

    uart_tx_buffered #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) dut_fmt (
        .clk(clk), .reset(reset), .data_in(fmt_data_in), .data_valid(fmt_valid),
        .data_ready(fmt_ready), .tx(fmt_tx), .tx_busy(fmt_busy), .fifo_count(fmt_count)
`ifdef UART_TX_BREAK_EN
        , .break_req(1'b0)
`endif
    );

    task test_reset;
        #1;
        checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
        checks++; if (data_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", data_ready); end
        checks++; if (fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", fifo_count); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task test_basic_frame;
        logic [10:0] exp;
        exp = 11'b01010010101;
        data_in = 8'hA5; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; data_in = 8'h00;
        checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL basic_latency: got %b expected 1", tx); end
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== exp[10 - i/4]) begin fails++; $display("[TB] FAIL basic_clk%0d: tx got %b expected %b", i, tx, exp[10 - i/4]); end
            checks++;
            if (tx_busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy%0d: got %b expected 1", i, tx_busy); end
        end
        @(negedge clk);
        checks++; if (tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_end: got %b expected 0", tx_busy); end
        checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL basic_idle: got %b expected 1", tx); end
    endtask

    task test_parity;
        logic [10:0] exp_even, exp_odd;
        exp_even = 11'b01000000011;
        exp_odd  = 11'b01000000001;
        data_in = 8'h01; data_valid = 1'b1;
        odd_data_in = 8'h01; odd_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; odd_valid = 1'b0;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== exp_even[10 - i/4]) begin fails++; $display("[TB] FAIL even_clk%0d: tx got %b expected %b", i, tx, exp_even[10 - i/4]); end
            checks++;
            if (odd_tx !== exp_odd[10 - i/4]) begin fails++; $display("[TB] FAIL odd_clk%0d: tx got %b expected %b", i, odd_tx, exp_odd[10 - i/4]); end
        end
        @(negedge clk);
        checks++; if (odd_busy !== 1'b0) begin fails++; $display("[TB] FAIL odd_busy_end: got %b expected 0", odd_busy); end
    endtask

    task test_format;
        logic [9:0] exp;
        exp = 10'b0101010111;
        fmt_data_in = 7'h55; fmt_valid = 1'b1;
        @(negedge clk);
        fmt_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (fmt_tx !== exp[9 - i/4]) begin fails++; $display("[TB] FAIL fmt_clk%0d: tx got %b expected %b", i, fmt_tx, exp[9 - i/4]); end
            checks++;
            if (fmt_busy !== 1'b1) begin fails++; $display("[TB] FAIL fmt_busy%0d: got %b expected 1", i, fmt_busy); end
        end
        @(negedge clk);
        checks++; if (fmt_busy !== 1'b0) begin fails++; $display("[TB] FAIL fmt_busy_end: got %b expected 0", fmt_busy); end
    endtask

    task test_back_to_back;
        logic [7:0] words [6];
        int   acc;
        logic will_accept;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = words[acc]; data_valid = 1'b1;
            will_accept = data_ready;
            @(negedge clk);
            if (will_accept) acc++;
        end
        data_valid = 1'b0;
        checks++; if (acc !== 5) begin fails++; $display("[TB] FAIL bp_accepted: got %0d expected 5", acc); end
        checks++; if (fifo_count !== 3'd4) begin fails++; $display("[TB] FAIL bp_full_count: got %0d expected 4", fifo_count); end
        checks++; if (data_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_full_ready: got %b expected 0", data_ready); end
        for (int k = 8; k <= 221; k++) begin
            @(negedge clk);
            if (k <= 220) begin
                checks++;
                if (tx_busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_busy%0d: got %b expected 1", k, tx_busy); end
            end else begin
                checks++; if (tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_busy_end: got %b expected 0", tx_busy); end
                checks++; if (fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL bp_count_end: got %0d expected 0", fifo_count); end
                checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL bp_tx_end: got %b expected 1", tx); end
            end
            if (k == 44) begin
                checks++; if (data_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_ready_before_pop: got %b expected 0", data_ready); end
            end
            if (k == 45) begin
                checks++; if (data_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_ready_after_pop: got %b expected 1", data_ready); end
                checks++; if (fifo_count !== 3'd3) begin fails++; $display("[TB] FAIL bp_count_after_pop: got %0d expected 3", fifo_count); end
            end
            if (k % 44 == 1 && k < 221) begin
                checks++; if (tx !== 1'b0) begin fails++; $display("[TB] FAIL bp_start%0d: got %b expected 0", k, tx); end
            end
            if (k % 44 == 0) begin
                checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL bp_stop%0d: got %b expected 1", k, tx); end
            end
        end
    endtask

    task test_reset_mid_frame;
        data_in = 8'hA5; data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h0F;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (17) @(negedge clk);
        checks++; if (tx !== 1'b0) begin fails++; $display("[TB] FAIL mid_bit3: got %b expected 0", tx); end
        checks++; if (fifo_count !== 3'd1) begin fails++; $display("[TB] FAIL mid_count: got %0d expected 1", fifo_count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_tx: got %b expected 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", tx_busy); end
        checks++; if (data_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", data_ready); end
        checks++; if (fifo_count !== 3'd0) begin fails++; $display("[TB] FAIL mid_reset_count: got %0d expected 0", fifo_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || tx_busy !== 1'b0) begin
                fails++; $display("[TB] FAIL post_reset%0d: tx/busy got %b/%b expected 1/0", i, tx, tx_busy);
            end
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task test_break;
        logic [10:0] exp;
        logic        want;
        exp = 11'b00011110001;
        data_in = 8'h3C; data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; break_req = 1'b1;
        @(negedge clk);
        break_req = 1'b0;
        for (int k = 1; k <= 137; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= 88)      want = 1'b0;
            else if (k <= 92) want = 1'b1;
            else if (k <= 136) want = exp[10 - (k - 93)/4];
            else              want = 1'b1;
            checks++;
            if (tx !== want) begin fails++; $display("[TB] FAIL brk_clk%0d: tx got %b expected %b", k, tx, want); end
            checks++;
            if (tx_busy !== (k <= 136)) begin fails++; $display("[TB] FAIL brk_busy%0d: got %b expected %b", k, tx_busy, (k <= 136)); end
            if (k == 50) begin
                checks++; if (fifo_count !== 3'd1) begin fails++; $display("[TB] FAIL brk_count: got %0d expected 1", fifo_count); end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        data_in = '0; data_valid = 1'b0; break_req = 1'b0;
        odd_data_in = '0; odd_valid = 1'b0;
        fmt_data_in = '0; fmt_valid = 1'b0;
        test_reset;
        $display("[TB] basic frame");
        test_basic_frame;
        $display("[TB] parity");
        test_parity;
        $display("[TB] format 7N2");
        test_format;
        $display("[TB] back to back");
        test_back_to_back;
        $display("[TB] reset mid frame");
        test_reset_mid_frame;
`ifdef UART_TX_BREAK_EN
        $display("[TB] break");
        test_break;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
